// File: rtl/ctrl_unit_mdu.sv
// RV32I/M decode-to-execute control register with a multi-cycle MDU sequencer
// that holds the front end while a mul/div is in flight.
module ctrl_unit_mdu #(
  parameter int MEXT       = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        in_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctrl,
  output logic [2:0]  ex_imm_sel,
  output logic [2:0]  ex_cmp_ctrl,
  output logic        ex_alu_src_a,
  output logic        ex_alu_src_b,
  output logic        ex_reg_write,
  output logic        ex_mem_w,
  output logic        ex_mem_r,
  output logic        ex_data_to_reg,
  output logic        ex_jalr,
  output logic        ex_is_branch,
  output logic [2:0]  ex_mdu_op,
  output logic        ex_is_mdu,
  output logic        ex_mdu_done,
  output logic        ex_illegal
);

  localparam logic [3:0] ALU_ADD = 4'b0001, ALU_SUB = 4'b0010, ALU_AND = 4'b0011,
                         ALU_OR  = 4'b0100, ALU_XOR = 4'b0101, ALU_SLL = 4'b0110,
                         ALU_SRL = 4'b0111, ALU_SLT = 4'b1000, ALU_SLTU = 4'b1001,
                         ALU_SRA = 4'b1010, ALU_PC4 = 4'b1011, ALU_B   = 4'b1100;
  localparam logic [2:0] IMM_I = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011,
                         IMM_S = 3'b100, IMM_U = 3'b101;
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [2:0] imm_sel;
    logic [2:0] cmp_ctrl;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_w;
    logic       mem_r;
    logic       data_to_reg;
    logic       jalr;
    logic       is_branch;
    logic [2:0] mdu_op;
    logic       is_mdu;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  ctrl_t      dec, ex_q;
  logic       valid_q, done_q, legal;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_fields;
  state_t     state, state_n;
  logic [5:0] cnt, cnt_n;
  logic       running, capture, start, finish;

  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign funct7        = inst[31:25];
  assign unused_fields = ^{inst[24:15], inst[11:7]};

  function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      7'b0110011: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) dec.alu_ctrl = alu_of_funct3(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'd0) dec.alu_ctrl = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'd5) dec.alu_ctrl = ALU_SRA;
        else if (funct7 == 7'b0000001 && MEXT != 0) begin
          // write-back is granted later by the sequencer, not at decode
          dec.reg_write = 1'b0;
          dec.is_mdu    = 1'b1;
          dec.mdu_op    = funct3;
        end else legal = 1'b0;
      end
      7'b0010011: begin
        dec.alu_ctrl  = alu_of_funct3(funct3);
        dec.alu_src_b = 1'b1;
        dec.imm_sel   = IMM_I;
        dec.reg_write = 1'b1;
        if (funct3 == 3'd1 && funct7 != 7'b0000000) legal = 1'b0;
        else if (funct3 == 3'd5) begin
          if (funct7 == 7'b0100000) dec.alu_ctrl = ALU_SRA;
          else if (funct7 != 7'b0000000) legal = 1'b0;
        end
      end
      7'b0000011: begin
        dec.alu_ctrl    = ALU_ADD;
        dec.alu_src_b   = 1'b1;
        dec.imm_sel     = IMM_I;
        dec.reg_write   = 1'b1;
        dec.mem_r       = 1'b1;
        dec.data_to_reg = 1'b1;
        legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'b0100011: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src_b = 1'b1;
        dec.imm_sel   = IMM_S;
        dec.mem_w     = 1'b1;
        legal = funct3 inside {3'd0, 3'd1, 3'd2};
      end
      7'b1100011: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_sel   = IMM_B;
        dec.is_branch = 1'b1;
        case (funct3)
          3'd0:    dec.cmp_ctrl = 3'b001;
          3'd1:    dec.cmp_ctrl = 3'b010;
          3'd4:    dec.cmp_ctrl = 3'b011;
          3'd5:    dec.cmp_ctrl = 3'b101;
          3'd6:    dec.cmp_ctrl = 3'b100;
          3'd7:    dec.cmp_ctrl = 3'b110;
          default: legal = 1'b0;
        endcase
      end
      7'b0110111: begin
        dec.alu_ctrl  = ALU_B;
        dec.alu_src_b = 1'b1;
        dec.imm_sel   = IMM_U;
        dec.reg_write = 1'b1;
      end
      7'b0010111: begin
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm_sel   = IMM_U;
        dec.reg_write = 1'b1;
      end
      7'b1101111: begin
        dec.alu_ctrl  = ALU_PC4;
        dec.alu_src_a = 1'b1;
        dec.imm_sel   = IMM_J;
        dec.reg_write = 1'b1;
      end
      7'b1100111: begin
        dec.alu_ctrl  = ALU_PC4;
        dec.alu_src_a = 1'b1;
        dec.imm_sel   = IMM_I;
        dec.reg_write = 1'b1;
        dec.jalr      = 1'b1;
        legal = (funct3 == 3'd0);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign running   = (state == MUL_RUN) || (state == DIV_RUN);
  assign stall_out = running;
  assign capture   = !stall_in && !running;
  assign start     = capture && in_valid && dec.is_mdu;
  assign finish    = running && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          if (dec.mdu_op[2]) begin
            state_n = DIV_RUN;
            cnt_n   = DIV_LOAD;
          end else begin
            state_n = MUL_RUN;
            cnt_n   = MUL_LOAD;
          end
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (finish) state_n = DONE;
        else        cnt_n   = cnt - 6'd1;
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  // A stall in DONE still retires the pulse: only reg_write/done drop, the rest holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (flush) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (finish) begin
        done_q         <= 1'b1;
        ex_q.reg_write <= 1'b1;
      end else if (capture) begin
        valid_q <= in_valid;
        ex_q    <= in_valid ? dec : '0;
      end else if (state == DONE) begin
        ex_q.reg_write <= 1'b0;
      end
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_ctrl    = ex_q.alu_ctrl;
  assign ex_imm_sel     = ex_q.imm_sel;
  assign ex_cmp_ctrl    = ex_q.cmp_ctrl;
  assign ex_alu_src_a   = ex_q.alu_src_a;
  assign ex_alu_src_b   = ex_q.alu_src_b;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_w       = ex_q.mem_w;
  assign ex_mem_r       = ex_q.mem_r;
  assign ex_data_to_reg = ex_q.data_to_reg;
  assign ex_jalr        = ex_q.jalr;
  assign ex_is_branch   = ex_q.is_branch;
  assign ex_mdu_op      = ex_q.mdu_op;
  assign ex_is_mdu      = ex_q.is_mdu;
  assign ex_mdu_done    = done_q;
  assign ex_illegal     = ex_q.illegal;

endmodule

// File: doc/ctrl_unit_mdu.md
CTRL_UNIT_MDU -- requirements
Module: ctrl_unit_mdu

Interface
REQ-001 SHALL have parameter MEXT, default 1, meaning RV32M mul/div decode enabled (0 = M-encodings illegal).
REQ-002 SHALL have parameter MUL_CYCLES, default 2, meaning execute cycles for MUL/MULH/MULHSU/MULHU, legal range 1..15.
REQ-003 SHALL have parameter DIV_CYCLES, default 32, meaning execute cycles for DIV/DIVU/REM/REMU, legal range 1..63.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst  in  1  reset, asynchronous, active-high
 inst  in  32  instruction in decode stage
 in_valid  in  1  inst valid
 stall_in  in  1  hazard-unit freeze of decode->execute register
 flush  in  1  kill decode and execute contents
 stall_out  out  1  MDU busy; front end holds inst
 ex_valid  out  1  execute-stage control valid
 ex_alu_ctrl  out  4  ALU op: ADD=0001, SUB=0010, AND=0011, OR=0100, XOR=0101, SLL=0110, SRL=0111, SLT=1000, SLTU=1001, SRA=1010, A+4=1011, Bout=1100, none=0000
 ex_imm_sel  out  3  I=001, B=010, J=011, S=100, U=101, none=000
 ex_cmp_ctrl  out  3  EQ=001, NE=010, LT=011, LTU=100, GE=101, GEU=110, none=000
 ex_alu_src_a, ex_alu_src_b, ex_reg_write, ex_mem_w, ex_mem_r, ex_data_to_reg, ex_jalr, ex_is_branch  out  1 each  standard RV32I control
 ex_mdu_op  out  3  funct3 of M instruction
 ex_is_mdu  out  1  M instruction in execute
 ex_mdu_done  out  1  one-cycle pulse, MDU result ready for write-back
 ex_illegal  out  1  undecodable instruction in execute

Function
REQ-005 SHALL decode the full RV32I subset (R, I-ALU, B, load LB/LH/LW/LBU/LHU, store SB/SH/SW, LUI, AUIPC, JAL, JALR funct3=0) with the encodings of REQ-004.
REQ-006 SHALL decode funct7=0000001 with opcode 0110011 as M-ops when MEXT=1; ex_alu_ctrl=0000, ex_reg_write asserted only with ex_mdu_done.
REQ-007 SHALL flag any other encoding (incl. M-ops when MEXT=0) as ex_illegal=1 with ex_reg_write=ex_mem_w=ex_mem_r=0 and all code fields 000/0000.
REQ-008 SHALL register all ex_* outputs (one-cycle decode latency); ex_valid=in_valid captured.
REQ-009 SHALL hold all ex_* registers unchanged while stall_in=1 or stall_out=1.
REQ-010 SHALL implement FSM IDLE, MUL_RUN, DIV_RUN, DONE with a 6-bit down-counter.
REQ-011 IDLE: on capture of a valid M-op, go to MUL_RUN (funct3 0..3, counter=MUL_CYCLES-1) or DIV_RUN (funct3 4..7, counter=DIV_CYCLES-1).
REQ-012 RUN states: stall_out=1; counter decrements each cycle; at counter=0 go to DONE.
REQ-013 DONE: stall_out=0, ex_mdu_done=1 and ex_reg_write=1 for exactly one cycle, then IDLE or RUN if a new M-op is captured the same edge.
REQ-014 SHALL make flush dominant: next edge clears ex_valid and all ex_* controls to 0, returns FSM to IDLE, counter to 0, suppresses a pending ex_mdu_done.
REQ-015 SHALL ignore stall_in while in a RUN state (MDU progress never freezes); stall_in in DONE delays capture only, not the done pulse.
REQ-016 SHALL treat in_valid=0 as a bubble: ex_valid=0, controls 0, FSM unaffected.

Reset
REQ-017 SHALL on rst=1, asynchronously and independently of clk, clear all ex_* outputs and stall_out to 0, FSM to IDLE, counter to 0, including mid-RUN.
REQ-018 SHALL resume normal capture on the first rising edge after rst deasserts.

Verification
REQ-019 ADD x3,x1,x2 (0x002081B3), in_valid=1 -> next cycle ex_valid=1, ex_alu_ctrl=0001, ex_reg_write=1, ex_imm_sel=000, stall_out=0.
REQ-020 MUL 0x022081B3, MUL_CYCLES=2 -> stall_out=1 for 2 cycles, then ex_mdu_done=1, ex_mdu_op=000, ex_reg_write=1 one cycle.
REQ-021 DIV 0x0220C1B3, DIV_CYCLES=32 -> stall_out=1 exactly 32 cycles, ex_mdu_op=100; flush at cycle 10 -> stall_out=0 next cycle, no done pulse.
REQ-022 MEXT=0, 0x022081B3 -> ex_illegal=1, ex_reg_write=0, stall_out never 1.
REQ-023 rst=1 mid DIV_RUN (async, between edges) -> stall_out and ex_valid 0 immediately; BEQ 0x00208463 after release -> ex_cmp_ctrl=001, ex_imm_sel=010, ex_is_branch=1.
REQ-024 stall_in=1 for 3 cycles with LW 0x0000A183 captured -> ex_* held; release -> next inst captured, ex_mem_r=1 seen only for LW.
